// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder: replays a raster-stored 128x128 frame from a single-port SRAM
// in LCU order to the SAO input. Per-LCU parameters ride along with each pixel.
// Back-pressure is absorbed by a one-entry skid behind the 1-cycle SRAM read.
module sao_lcu_feeder #(
    parameter int FRAME_W = 128,
    parameter int PRM_W   = 24
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [1:0]                           cfg_lcu_size,
    output logic [$clog2(FRAME_W*FRAME_W)-1:0]   sram_a,
    output logic                                 sram_cen,
    input  logic [7:0]                           sram_q,
    output logic [5:0]                           prm_idx,
    input  logic [PRM_W-1:0]                     prm_data,
    input  logic                                 busy,
    output logic                                 in_en,
    output logic [7:0]                           din,
    output logic [1:0]                           sao_type,
    output logic [4:0]                           sao_band_pos,
    output logic                                 sao_eo_class,
    output logic [15:0]                          sao_offset,
    output logic [2:0]                           lcu_x,
    output logic [2:0]                           lcu_y,
    output logic [1:0]                           lcu_size,
    output logic                                 done
);
    localparam int AW = $clog2(FRAME_W*FRAME_W);
    localparam int CW = $clog2(FRAME_W);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       size_q, size_d;
    logic [5:0]       col_q, col_d, row_q, row_d;
    logic [2:0]       lx_q, lx_d, ly_q, ly_d;

    // read in flight: metadata of the LCU the address belonged to
    logic             rd_vld_q, rd_vld_d;
    logic [PRM_W-1:0] rd_prm_q, rd_prm_d;
    logic [2:0]       rd_lx_q, rd_lx_d, rd_ly_q, rd_ly_d;

    // skid entry: a returned pixel that met busy=1
    logic             sk_vld_q, sk_vld_d;
    logic [7:0]       sk_pix_q, sk_pix_d;
    logic [PRM_W-1:0] sk_prm_q, sk_prm_d;
    logic [2:0]       sk_lx_q, sk_lx_d, sk_ly_q, sk_ly_d;

    // presented pixel and its LCU context
    logic             in_en_q, in_en_d;
    logic [7:0]       din_q, din_d;
    logic [PRM_W-1:0] prm_q, prm_d;
    logic [2:0]       olx_q, olx_d, oly_q, oly_d;

    logic [5:0]       n_m1;
    logic [2:0]       lcu_m1;
    logic [CW-1:0]    yabs, xabs;
    logic [5:0]       lidx;
    logic             issue, last_addr;

    // size-dependent limits, absolute pixel coordinates and table index
    always_comb begin
        case (size_q)
            2'd0: begin
                n_m1   = 6'd15;
                lcu_m1 = 3'd7;
                yabs   = CW'({ly_q, row_q[3:0]});
                xabs   = CW'({lx_q, col_q[3:0]});
                lidx   = {ly_q, lx_q};
            end
            2'd1: begin
                n_m1   = 6'd31;
                lcu_m1 = 3'd3;
                yabs   = CW'({ly_q[1:0], row_q[4:0]});
                xabs   = CW'({lx_q[1:0], col_q[4:0]});
                lidx   = {2'b00, ly_q[1:0], lx_q[1:0]};
            end
            default: begin
                n_m1   = 6'd63;
                lcu_m1 = 3'd1;
                yabs   = CW'({ly_q[0], row_q});
                xabs   = CW'({lx_q[0], col_q});
                lidx   = {4'b0000, ly_q[0], lx_q[0]};
            end
        endcase
        issue     = (state_q == S_STREAM) && !busy && !sk_vld_q;
        last_addr = (col_q == n_m1) && (row_q == n_m1) &&
                    (lx_q == lcu_m1) && (ly_q == lcu_m1);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next state: drain waits for both the in-flight read and the skid
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: if (issue && last_addr) state_d = S_DRAIN;
            S_DRAIN:  if (!rd_vld_q && !sk_vld_q) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the read is decided in the cycle before the edge that issues it
    always_comb begin
        sram_cen = !issue;
        sram_a   = (state_q == S_STREAM) ? AW'({yabs, xabs}) : '0;
        prm_idx  = lidx;
        done     = (state_q == S_DONE);
    end

    // counters, read tracking, skid and presentation
    always_comb begin
        size_d   = size_q;
        col_d    = col_q;
        row_d    = row_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        rd_vld_d = issue;
        rd_prm_d = rd_prm_q;
        rd_lx_d  = rd_lx_q;
        rd_ly_d  = rd_ly_q;
        sk_vld_d = sk_vld_q;
        sk_pix_d = sk_pix_q;
        sk_prm_d = sk_prm_q;
        sk_lx_d  = sk_lx_q;
        sk_ly_d  = sk_ly_q;
        in_en_d  = 1'b0;
        din_d    = din_q;
        prm_d    = prm_q;
        olx_d    = olx_q;
        oly_d    = oly_q;

        if (state_q == S_IDLE && start) begin
            size_d = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
            col_d  = '0;
            row_d  = '0;
            lx_d   = '0;
            ly_d   = '0;
        end else if (issue) begin
            rd_prm_d = prm_data;
            rd_lx_d  = lx_q;
            rd_ly_d  = ly_q;
            if (col_q != n_m1) col_d = col_q + 6'd1;
            else begin
                col_d = '0;
                if (row_q != n_m1) row_d = row_q + 6'd1;
                else begin
                    row_d = '0;
                    if (lx_q != lcu_m1) lx_d = lx_q + 3'd1;
                    else begin
                        lx_d = '0;
                        ly_d = (ly_q != lcu_m1) ? ly_q + 3'd1 : 3'd0;
                    end
                end
            end
        end

        // the skid and a returning read never coexist: issue needs an empty skid
        if (sk_vld_q && !busy) begin
            in_en_d  = 1'b1;
            din_d    = sk_pix_q;
            prm_d    = sk_prm_q;
            olx_d    = sk_lx_q;
            oly_d    = sk_ly_q;
            sk_vld_d = 1'b0;
        end else if (rd_vld_q && !busy) begin
            in_en_d = 1'b1;
            din_d   = sram_q;
            prm_d   = rd_prm_q;
            olx_d   = rd_lx_q;
            oly_d   = rd_ly_q;
        end else if (rd_vld_q) begin
            sk_vld_d = 1'b1;
            sk_pix_d = sram_q;
            sk_prm_d = rd_prm_q;
            sk_lx_d  = rd_lx_q;
            sk_ly_d  = rd_ly_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            rd_vld_q <= 1'b0;
            rd_prm_q <= '0;
            rd_lx_q  <= '0;
            rd_ly_q  <= '0;
            sk_vld_q <= 1'b0;
            sk_pix_q <= '0;
            sk_prm_q <= '0;
            sk_lx_q  <= '0;
            sk_ly_q  <= '0;
            in_en_q  <= 1'b0;
            din_q    <= '0;
            prm_q    <= '0;
            olx_q    <= '0;
            oly_q    <= '0;
        end else begin
            size_q   <= size_d;
            col_q    <= col_d;
            row_q    <= row_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            rd_vld_q <= rd_vld_d;
            rd_prm_q <= rd_prm_d;
            rd_lx_q  <= rd_lx_d;
            rd_ly_q  <= rd_ly_d;
            sk_vld_q <= sk_vld_d;
            sk_pix_q <= sk_pix_d;
            sk_prm_q <= sk_prm_d;
            sk_lx_q  <= sk_lx_d;
            sk_ly_q  <= sk_ly_d;
            in_en_q  <= in_en_d;
            din_q    <= din_d;
            prm_q    <= prm_d;
            olx_q    <= olx_d;
            oly_q    <= oly_d;
        end
    end

    assign in_en        = in_en_q;
    assign din          = din_q;
    assign sao_type     = prm_q[23:22];
    assign sao_band_pos = prm_q[21:17];
    assign sao_eo_class = prm_q[16];
    assign sao_offset   = prm_q[15:0];
    assign lcu_x        = olx_q;
    assign lcu_y        = oly_q;
    assign lcu_size     = size_q;

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Bench for sao_lcu_feeder: SRAM and parameter-table models, an LCU-order
// expected-pixel queue built from nested loops, and a per-cycle compare.
module tb_sao_lcu_feeder;
    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [1:0]  cfg;
    logic [13:0] sram_a;
    logic        sram_cen;
    logic [7:0]  sram_q = 8'd0;
    logic [5:0]  prm_idx;
    logic [23:0] prm_data;
    logic        in_en, sao_eo_class, done;
    logic [7:0]  din;
    logic [1:0]  sao_type, lcu_size;
    logic [4:0]  sao_band_pos;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x, lcu_y;

    sao_lcu_feeder dut (
        .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_q(sram_q),
        .prm_idx(prm_idx), .prm_data(prm_data), .busy(busy),
        .in_en(in_en), .din(din), .sao_type(sao_type), .sao_band_pos(sao_band_pos),
        .sao_eo_class(sao_eo_class), .sao_offset(sao_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] golden(int a);
        return 8'(a * 37 + (a >> 7) * 11 + 3);
    endfunction

    // table entry i: offset = i, other fields derived from i so they vary
    function automatic logic [23:0] prm_of(int i);
        logic [5:0] b;
        b = 6'(i);
        return {b[1:0], b[5:1], b[0], 10'd0, b};
    endfunction

    assign prm_data = prm_of(int'(prm_idx));

    // SRAM: read data valid the cycle after chip enable is sampled low
    always @(posedge clk) if (!sram_cen) sram_q <= golden(int'(sram_a));

    logic busy_smp = 1'b0;
    always @(posedge clk) busy_smp <= busy;

    typedef struct {
        logic [7:0]  pix;
        logic [2:0]  lx;
        logic [2:0]  ly;
        logic [23:0] prm;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   pix_n = 0, run_id = 0;
    logic chk_en = 1'b0, last_flag = 1'b0, busy_rand = 1'b0;
    logic [1:0] exp_size = 2'd0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (pixel %0d)", name, got, exp, pix_n);
        end
    endtask

    // frame in LCU order, built straight from the address formula
    task automatic build_model(int sz);
        int n, per;
        n   = 16 << sz;
        per = 128 / n;
        exp_q.delete();
        for (int ly = 0; ly < per; ly++)
            for (int lx = 0; lx < per; lx++)
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++) begin
                        exp_t e;
                        e.pix = golden((ly * n + r) * 128 + lx * n + c);
                        e.lx  = 3'(lx);
                        e.ly  = 3'(ly);
                        e.prm = prm_of(ly * per + lx);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_in_en"},    32'(in_en), 0);
        check({tag, "_din"},      32'(din), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_sram_cen"}, 32'(sram_cen), 1);
        check({tag, "_sram_a"},   32'(sram_a), 0);
        check({tag, "_sao"},      32'({sao_type, sao_band_pos, sao_eo_class, sao_offset}), 0);
        check({tag, "_lcu_xy"},   32'({lcu_x, lcu_y}), 0);
        check({tag, "_lcu_size"}, 32'(lcu_size), 0);
        check({tag, "_prm_idx"},  32'(prm_idx), 0);
    endtask

    // per-cycle compare against the model queue
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("done", 32'(done), 32'(last_flag));
                last_flag = 1'b0;
                if (busy_smp) check("in_en_after_busy", 32'(in_en), 0);
                if (in_en) begin
                    if (exp_q.size() == 0) check("extra_pixel", 32'(in_en), 0);
                    else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("din", 32'(din), 32'(e.pix));
                        check("lcu_xy", 32'({lcu_x, lcu_y}), 32'({e.lx, e.ly}));
                        check("sao", 32'({sao_type, sao_band_pos, sao_eo_class, sao_offset}), 32'(e.prm));
                        check("lcu_size", 32'(lcu_size), 32'(exp_size));
                        // hand-derived anchors
                        if (run_id == 1 && pix_n == 0)    check("r1_first_pix", 32'(din), 32'(golden(0)));
                        if (run_id == 1 && pix_n == 4864) check("r1_offset_3_2", 32'(sao_offset), 19);
                        if (run_id == 1 && pix_n == 256)  check("r1_lcu1_x", 32'(lcu_x), 1);
                        if (run_id == 2 && pix_n == 64)   check("r2_pix65_addr128", 32'(din), 32'(golden(128)));
                        if (run_id == 2 && pix_n == 4096) check("r2_lcu10_addr64", 32'(din), 32'(golden(64)));
                        if (run_id == 2 && pix_n == 4096) check("r2_lcu10_x", 32'(lcu_x), 1);
                        pix_n++;
                        if (exp_q.size() == 0) last_flag = 1'b1;
                    end
                end
            end
        end
    end

    // busy driver; the random mode ends with a 3-cycle stall on the final pixel
    initial begin
        int tail;
        tail = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy_rand) busy = 1'b0;
            else if (tail > 0) begin
                busy = 1'b1;
                tail--;
            end else if (sram_a == 14'h3FFF) begin
                busy = 1'b0;
                tail = 3;
            end else busy = ($urandom_range(0, 7) == 0);
        end
    end

    task automatic run_frame(int id, logic [1:0] c, int sz, bit mid_start, bit chk_lat);
        int cyc, first;
        bit pulsed;
        run_id = id;
        build_model(sz);
        exp_size = 2'(sz);
        pix_n = 0;
        pulsed = 1'b0;
        @(negedge clk);
        cfg   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg   = 2'd0;
        cyc   = 0;
        first = -1;
        while (!done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (in_en && first < 0) first = cyc;
            if (mid_start && !pulsed && pix_n >= 3000) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 1);
        check("all_pixels", 32'(exp_q.size()), 0);
        if (chk_lat) check("first_latency", 32'(first), 2);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        cfg   = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_frame(1, 2'd0, 0, 1'b0, 1'b1);   // 16x16, unstalled
        run_frame(2, 2'd2, 2, 1'b0, 1'b1);   // 64x64, unstalled
        busy_rand = 1'b1;
        run_frame(3, 2'd1, 1, 1'b0, 1'b0);   // 32x32 with back-pressure
        busy_rand = 1'b0;
        @(negedge clk);

        // partial frame, then asynchronous reset mid-stream
        run_id = 4;
        build_model(1);
        exp_size = 2'd1;
        pix_n = 0;
        cfg   = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (pix_n < 1100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("partial_reached", 32'(pix_n >= 1100), 1);
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_vals("mid");
        @(negedge clk);
        reset = 1'b0;
        last_flag = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'(in_en | done), 0);

        // fresh start after reset: reserved size, start pulsed mid-frame
        run_frame(5, 2'd3, 2, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
